// File: rtl/neuron_param_loader_if.sv
// neuron_param_loader_if
//   Byte-serial valid/ready command stream feeding neuron_param_loader.
//   Signals:
//     data_in     8-bit command/payload byte (source -> loader)
//     data_valid  byte on data_in is valid  (source -> loader)
//     data_ready  loader accepts a byte this cycle (loader -> source)
//   Modports:
//     master  byte source (host / testbench)
//     slave   byte sink (neuron_param_loader)
interface neuron_param_loader_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/neuron_param_loader.sv
// neuron_param_loader
//   Byte-serial configuration and stimulus front-end for neuron_lif.
//   Framed commands arrive on an 8-bit valid/ready stream. Weights and neuron
//   parameters are staged in shadow registers and copied to the active set in
//   one edge on COMMIT. Input spike vectors are written straight into the
//   active inputs register; completing a vector issues a one-cycle enable.
//
//   Header opcodes (data_in[3:0], upper nibble ignored):
//     0x1 WEIGHTS  SYNAPSES/8 payload bytes, LSB byte first -> shadow weights
//     0x2 PARAMS   3 payload bytes: threshold, {factor,-,shift}, addend
//     0x3 INPUTS   SYNAPSES/8 payload bytes -> active inputs, then STEP
//     0x4 COMMIT   shadow -> active, no payload
//     other        sets sticky cmd_error, byte discarded
//
//   Ports:
//     clk               clock, rising edge
//     rst_n             asynchronous active-low reset
//     stream            byte stream (slave modport: data_in, data_valid, data_ready)
//     weights           active weights to neuron_lif
//     inputs            active input spike vector to neuron_lif
//     threshold         active threshold
//     shift             active decay shift
//     batchnorm_factor  active batchnorm factor (4'b0100 = scale 1)
//     batchnorm_addend  active batchnorm addend, signed
//     neuron_enable     one-cycle step strobe to neuron_lif
//     busy              a frame is in progress
//     cmd_error         sticky unknown-opcode flag, cleared only by reset
module neuron_param_loader #(
  parameter int SYNAPSES              = 32,
  parameter int THRESHOLD_BITS        = 6,
  parameter int BATCHNORM_ADDEND_BITS = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  neuron_param_loader_if.slave                    stream,
  output logic        [SYNAPSES-1:0]              weights,
  output logic        [SYNAPSES-1:0]              inputs,
  output logic        [THRESHOLD_BITS-1:0]        threshold,
  output logic        [2:0]                       shift,
  output logic        [3:0]                       batchnorm_factor,
  output logic signed [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend,
  output logic                                    neuron_enable,
  output logic                                    busy,
  output logic                                    cmd_error
);

  localparam int N     = SYNAPSES / 8;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  // One spare bit so the counter also covers the 3-byte PARAMS frame when N is small.
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [3:0] OP_WEIGHTS = 4'h1;
  localparam logic [3:0] OP_PARAMS  = 4'h2;
  localparam logic [3:0] OP_INPUTS  = 4'h3;
  localparam logic [3:0] OP_COMMIT  = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WEIGHTS,
    ST_PARAMS,
    ST_INPUTS,
    ST_STEP
  } state_t;

  state_t                              state;
  logic [CNT_W-1:0]                    cnt;
  logic [IDX_W-1:0]                    idx;
  logic                                accept;

  logic [N-1:0][7:0]                   shadow_weights;
  logic [N-1:0][7:0]                   active_weights;
  logic [N-1:0][7:0]                   inputs_q;
  logic [THRESHOLD_BITS-1:0]           shadow_threshold;
  logic [2:0]                          shadow_shift;
  logic [3:0]                          shadow_factor;
  logic [BATCHNORM_ADDEND_BITS-1:0]    shadow_addend;

  // The STEP cycle is the only one in which a byte is refused; this holds off
  // a back-to-back header until the enable strobe has been issued.
  assign stream.data_ready = (state != ST_STEP);
  assign busy              = (state != ST_IDLE);
  assign accept            = stream.data_valid && stream.data_ready;
  assign idx               = cnt[IDX_W-1:0];

  assign weights = active_weights;
  assign inputs  = inputs_q;

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every register samples pre-edge values; the shadow and
  // active register files are reset as well, because a reset must discard a
  // partially loaded shadow set rather than let it be committed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      shadow_weights   <= '0;
      active_weights   <= '0;
      inputs_q         <= '0;
      shadow_threshold <= '1;
      shadow_shift     <= '0;
      shadow_factor    <= 4'b0100;
      shadow_addend    <= '0;
      threshold        <= '1;
      shift            <= '0;
      batchnorm_factor <= 4'b0100;
      batchnorm_addend <= '0;
      neuron_enable    <= 1'b0;
      cmd_error        <= 1'b0;
    end else begin
      neuron_enable <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt <= '0;
            case (stream.data_in[3:0])
              OP_WEIGHTS: state <= ST_WEIGHTS;
              OP_PARAMS:  state <= ST_PARAMS;
              OP_INPUTS:  state <= ST_INPUTS;
              OP_COMMIT: begin
                // Whole set moves on one edge: neuron_lif never sees a mix.
                active_weights   <= shadow_weights;
                threshold        <= shadow_threshold;
                shift            <= shadow_shift;
                batchnorm_factor <= shadow_factor;
                batchnorm_addend <= shadow_addend;
              end
              default:    cmd_error <= 1'b1;
            endcase
          end
        end

        ST_WEIGHTS: begin
          if (accept) begin
            shadow_weights[idx] <= stream.data_in;
            if (cnt == CNT_LAST) state <= ST_IDLE;
            else                 cnt   <= cnt + CNT_ONE;
          end
        end

        ST_PARAMS: begin
          if (accept) begin
            case (cnt)
              CNT_W'(0): shadow_threshold <= stream.data_in[THRESHOLD_BITS-1:0];
              CNT_W'(1): begin
                shadow_shift  <= stream.data_in[2:0];
                shadow_factor <= stream.data_in[7:4];
              end
              default: begin
                shadow_addend <= stream.data_in[BATCHNORM_ADDEND_BITS-1:0];
                state         <= ST_IDLE;
              end
            endcase
            if (cnt != CNT_W'(2)) cnt <= cnt + CNT_ONE;
          end
        end

        ST_INPUTS: begin
          if (accept) begin
            inputs_q[idx] <= stream.data_in;
            if (cnt == CNT_LAST) begin
              state         <= ST_STEP;
              neuron_enable <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end

        ST_STEP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_param_loader.sv
// tb_neuron_param_loader
//   Self-checking bench for neuron_param_loader (SYNAPSES=32). A cycle table
//   covers weight load/commit and a gapped input frame; hand-written sequences
//   cover reset values, params, opcode errors, back-to-back frames and a reset
//   in the middle of a weights frame.
module tb_neuron_param_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] weights;
  logic [31:0] inputs;
  logic [5:0]  threshold;
  logic [2:0]  shift;
  logic [3:0]  batchnorm_factor;
  logic [4:0]  batchnorm_addend;
  logic        neuron_enable;
  logic        busy;
  logic        cmd_error;

  neuron_param_loader_if stream ();

  neuron_param_loader #(
    .SYNAPSES              (32),
    .THRESHOLD_BITS        (6),
    .BATCHNORM_ADDEND_BITS (5)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stream           (stream.slave),
    .weights          (weights),
    .inputs           (inputs),
    .threshold        (threshold),
    .shift            (shift),
    .batchnorm_factor (batchnorm_factor),
    .batchnorm_addend (batchnorm_addend),
    .neuron_enable    (neuron_enable),
    .busy             (busy),
    .cmd_error        (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Enable-pulse monitor: records the posedge index of every strobe.
  int cyc = 0;
  int en_count = 0;
  int en_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && neuron_enable) begin
      en_count <= en_count + 1;
      en_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_weights"},   64'(weights), 64'h0);
    check({tag, "_inputs"},    64'(inputs), 64'h0);
    check({tag, "_threshold"}, 64'(threshold), 64'h3F);
    check({tag, "_shift"},     64'(shift), 64'h0);
    check({tag, "_factor"},    64'(batchnorm_factor), 64'h4);
    check({tag, "_addend"},    64'(batchnorm_addend), 64'h0);
    check({tag, "_enable"},    64'(neuron_enable), 64'h0);
    check({tag, "_cmd_error"}, 64'(cmd_error), 64'h0);
    check({tag, "_busy"},      64'(busy), 64'h0);
    check({tag, "_ready"},     64'(stream.data_ready), 64'h1);
  endtask

  // Presents a byte from a falling edge and returns on the rising edge that
  // accepts it; gives up after 20 refused cycles.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    stream.data_in    = b;
    stream.data_valid = 1'b1;
    n = 0;
    while (!stream.data_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(posedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    stream.data_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]  din;
    logic        vld;
    logic        busy;
    logic        rdy;
    logic        en;
    logic [31:0] inp;
    logic [31:0] wts;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int base;
    int sep;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sep;

    rst_n             = 1'b1;
    stream.data_in    = 8'h00;
    stream.data_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table: weights load + commit, then gapped input frame + step ----
    //               din    vld   busy  rdy   en    inputs         weights
    tbl.push_back('{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000});
    tbl.push_back('{8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000});
    tbl.push_back('{8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000});
    tbl.push_back('{8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000});
    tbl.push_back('{8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000});
    tbl.push_back('{8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h44332211});
    tbl.push_back('{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h44332211});
    tbl.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000000FF, 32'h44332211});
    tbl.push_back('{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000FF, 32'h44332211});
    tbl.push_back('{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000FF, 32'h44332211});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000000FF, 32'h44332211});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000FF, 32'h44332211});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000FF, 32'h44332211});
    tbl.push_back('{8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000F00FF, 32'h44332211});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000F00FF, 32'h44332211});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000F00FF, 32'h44332211});
    tbl.push_back('{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 32'h800F00FF, 32'h44332211});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800F00FF, 32'h44332211});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800F00FF, 32'h44332211});

    base = en_count;
    for (int i = 0; i < tbl.size(); i++) begin
      stream.data_in    = tbl[i].din;
      stream.data_valid = tbl[i].vld;
      @(negedge clk);
      check($sformatf("row%0d_busy", i),    64'(busy),              64'(tbl[i].busy));
      check($sformatf("row%0d_ready", i),   64'(stream.data_ready), 64'(tbl[i].rdy));
      check($sformatf("row%0d_enable", i),  64'(neuron_enable),     64'(tbl[i].en));
      check($sformatf("row%0d_inputs", i),  64'(inputs),            64'(tbl[i].inp));
      check($sformatf("row%0d_weights", i), 64'(weights),           64'(tbl[i].wts));
    end
    check("table_enable_pulses", 64'(en_count - base), 64'd1);

    // ---- params: staged until commit ----
    send_byte(8'h02);
    send_byte(8'h2A);
    send_byte(8'h85);
    send_byte(8'h1B);
    end_frame();
    check("params_uncommitted_threshold", 64'(threshold), 64'h3F);
    check("params_uncommitted_factor",    64'(batchnorm_factor), 64'h4);
    send_byte(8'h04);
    end_frame();
    check("params_threshold", 64'(threshold), 64'h2A);
    check("params_shift",     64'(shift), 64'h5);
    check("params_factor",    64'(batchnorm_factor), 64'h8);
    check("params_addend",    64'(batchnorm_addend), 64'h1B);
    check("params_cmd_error", 64'(cmd_error), 64'h0);

    // ---- unknown opcode: sticky error, later headers still honoured ----
    send_byte(8'h07);
    end_frame();
    check("err_set",  64'(cmd_error), 64'h1);
    check("err_busy", 64'(busy), 64'h0);
    send_byte(8'h02);
    send_byte(8'hD1);
    send_byte(8'h06);
    send_byte(8'hE3);
    send_byte(8'hF4);
    end_frame();
    check("err_sticky",          64'(cmd_error), 64'h1);
    check("err_commit_threshold", 64'(threshold), 64'h11);
    check("err_commit_shift",    64'(shift), 64'h6);
    check("err_commit_factor",   64'(batchnorm_factor), 64'h0);
    check("err_commit_addend",   64'(batchnorm_addend), 64'h03);
    check("err_weights_kept",    64'(weights), 64'h44332211);

    // ---- back-to-back input frames: second header waits out STEP ----
    base = en_count;
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h03);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    end_frame();
    repeat (3) @(negedge clk);
    check("b2b_pulses", 64'(en_count - base), 64'd2);
    if (en_count - base == 2) begin
      sep = en_cyc[base + 1] - en_cyc[base];
      check("b2b_gap_ge5", 64'(sep >= 5), 64'h1);
    end
    check("b2b_inputs", 64'(inputs), 64'hD4C3B2A1);
    check("b2b_idle",   64'(busy), 64'h0);

    // ---- asynchronous reset in the middle of a weights frame ----
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #1 check("midframe_busy", 64'(busy), 64'h1);
    #1 stream.data_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h04);
    end_frame();
    check("after_reset_commit_weights",   64'(weights), 64'h0);
    check("after_reset_commit_threshold", 64'(threshold), 64'h3F);
    check("after_reset_cmd_error",        64'(cmd_error), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_param_loader.md
Name: neuron_param_loader

Overview:
- Byte-serial configuration and stimulus front-end that sits directly upstream of neuron_lif.
- Accepts framed commands over an 8-bit valid/ready stream.
- Stages weights and neuron parameters in shadow registers and commits them atomically to active registers that drive neuron_lif.
- Latches input spike vectors and issues a one-cycle neuron enable strobe per completed input vector.

Parameters:
- SYNAPSES, 32, synapse count; must be a multiple of 8, range 8..64.
- THRESHOLD_BITS, 6, width of threshold output; at most 8.
- BATCHNORM_ADDEND_BITS, 5, width of batchnorm_addend output; at most 8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  8  command/payload byte.
- data_valid  in  1  byte on data_in is valid.
- data_ready  out  1  block accepts a byte this cycle.
- weights  out  SYNAPSES  active weights to neuron_lif.
- inputs  out  SYNAPSES  active input spike vector to neuron_lif.
- threshold  out  THRESHOLD_BITS  active threshold.
- shift  out  3  active decay shift.
- batchnorm_factor  out  4  active BN factor.
- batchnorm_addend  out  BATCHNORM_ADDEND_BITS  active BN addend, signed.
- neuron_enable  out  1  one-cycle step strobe to neuron_lif enable.
- busy  out  1  high while a frame is in progress (state != IDLE).
- cmd_error  out  1  sticky; an unknown opcode was received.

Behaviour:
- Byte transfer: a byte is accepted on a rising edge with data_valid=1 and data_ready=1. data_ready is combinational, equals 1 in every state except STEP.
- Reset values:
  - Shadow and active weights = 0; inputs = 0.
  - threshold = all ones; shift = 0; batchnorm_factor = 4'b0100 (scale 1); batchnorm_addend = 0.
  - neuron_enable = 0; cmd_error = 0; state IDLE; byte counter 0.
- FSM states: IDLE, WEIGHTS, PARAMS, INPUTS, STEP.
- In IDLE, an accepted byte is a header; the opcode is data_in[3:0], upper nibble ignored:
  - 0x1: go to WEIGHTS; counter cleared.
  - 0x2: go to PARAMS; counter cleared.
  - 0x3: go to INPUTS; counter cleared.
  - 0x4 COMMIT: on the same edge, all shadow registers are copied to active; stay IDLE. The new values are visible the cycle after the header is accepted.
  - Any other opcode: set cmd_error; stay IDLE; byte discarded.
- WEIGHTS: expects N = SYNAPSES/8 payload bytes.
  - Byte k (k = 0..N-1) is written to shadow weights[8k+7:8k], LSB byte first.
  - After byte N-1, return to IDLE.
  - Active weights are unchanged until COMMIT.
- PARAMS: expects exactly 3 payload bytes, then returns to IDLE.
  - Byte0 low THRESHOLD_BITS bits -> shadow threshold; upper bits ignored.
  - Byte1 [2:0] -> shadow shift; [7:4] -> shadow factor; [3] ignored.
  - Byte2 low BATCHNORM_ADDEND_BITS bits -> shadow addend.
- INPUTS: N payload bytes written directly into the active inputs register, same byte order as weights.
  - Partial updates are visible while the frame is in progress.
  - After byte N-1, go to STEP.
- STEP: lasts exactly one cycle.
  - neuron_enable=1 and data_ready=0 for that cycle.
  - Next state IDLE.
  - neuron_enable is registered: it asserts the cycle after the last input byte is accepted, when the full input vector is already present on inputs.
- Timing and counters:
  - Stalls (data_valid=0) inside a frame are allowed indefinitely; the counter holds.
  - Byte counter is $clog2(SYNAPSES/8)+1 bits minimum, cleared on frame entry, never wraps past N-1.
- Concurrency: COMMIT during neuron operation is safe; neuron_lif sees the old set up to the edge and the new set after it. There is no mixed state.
- Reset mid-frame: asserting rst_n=0 returns all registers to reset values immediately (asynchronously), including discarding a partially loaded shadow. Deassertion is synchronous to clk.
- Error handling:
  - cmd_error clears only on reset.
  - Header bytes received within a frame are treated as payload; there is no resynchronisation other than reset.

Test Plan:
- Reset: hold rst_n=0 mid-WEIGHTS frame -> all outputs at reset values, busy=0, data_ready=1, threshold=6'h3F.
- Weight load + commit, SYNAPSES=32: send 0x01, then 0x11,0x22,0x33,0x44.
  - weights stays 0 until 0x04 is sent.
  - After commit, weights=32'h44332211 one cycle after header accept.
- Params: send 0x02, 0x2A, 0x85, 0x1B, then 0x04 -> threshold=6'h2A, shift=3'd5, batchnorm_factor=4'b1000, batchnorm_addend=5'h1B (-5).
- Step: send 0x03, then 0xFF,0x00,0x0F,0x80 with 2-cycle data_valid gaps.
  - inputs=32'h800F00FF.
  - neuron_enable high exactly one cycle, the cycle after last byte.
  - data_ready=0 that cycle; no enable otherwise.
- Error: send 0x07 -> cmd_error=1 and stays 1; a following 0x04 header is still honoured.
- Back-to-back: 0x03 frame, then an immediately presented next 0x03 frame -> second header waits during STEP; two enable pulses result, separated by ≥5 cycles.
